seg7_indicator_ctrl: RTL and testbench

Downstream display stage for the counter FSM. It consumes the 8-bit indication value (N1/N2 switch data or sawtooth count) and the 2-bit state code. The value is converted to decimal with a sequential double-dabble converter. The block then time-multiplexes four 7-segment digits: three decimal digits plus one state digit.

---
 rtl/seg7_indicator_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg7_indicator_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_indicator_ctrl.sv
// Display stage: sequential double-dabble conversion of data_i plus a four-digit
// multiplexed 7-segment scan (units, tens, hundreds, mode).
//   state | meaning
//   IDLE  | waiting for data_i to differ from the latched value
//   SHIFT | eight add-3/shift iterations
//   DONE  | publish converted value on bcd_o
module seg7_indicator_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clc_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic [1:0]  mode_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic [11:0] bcd_o,
  output logic        busy_o
);

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]      AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  conv_state_t state_q, state_d;
  logic [7:0]  latch_q;
  logic [19:0] sreg_q;
  logic [19:0] sreg_adj;
  logic [2:0]  bit_cnt_q;
  logic [11:0] bcd_q;

  logic [CNT_W-1:0] scan_cnt_q;
  logic [1:0]       digit_idx_q;
  logic [6:0]       pat;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic [3:0]       an_q;

  always_ff @(posedge clc_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_i != latch_q) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on the three BCD nibbles before each shift
  always_comb begin
    sreg_adj = sreg_q;
    for (int i = 0; i < 3; i++) begin
      if (sreg_q[8+4*i +: 4] >= 4'd5)
        sreg_adj[8+4*i +: 4] = sreg_q[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      latch_q   <= 8'd0;
      sreg_q    <= 20'd0;
      bit_cnt_q <= 3'd0;
      bcd_q     <= 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_i != latch_q) begin
            latch_q   <= data_i;
            sreg_q    <= {12'd0, data_i};
            bit_cnt_q <= 3'd0;
          end
        end
        SHIFT: begin
          sreg_q    <= {sreg_adj[18:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        DONE:    bcd_q <= sreg_q[19:8];
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign bcd_o  = bcd_q;

  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= digit_idx_q + 2'd1;
    end else begin
      scan_cnt_q  <= scan_cnt_q + 1'b1;
    end
  end

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Leading-zero blanking on tens/hundreds; mode digit shows a dash for idle
  always_comb begin
    pat = 7'h00;
    case (digit_idx_q)
      2'd0: pat = seg_digit(bcd_q[3:0]);
      2'd1: if (bcd_q[11:4] != 8'd0) pat = seg_digit(bcd_q[7:4]);
      2'd2: if (bcd_q[11:8] != 4'd0) pat = seg_digit(bcd_q[11:8]);
      2'd3: pat = (mode_i == 2'd0) ? 7'h40 : seg_digit({2'b00, mode_i});
    endcase
  end

  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      seg_q <= SEG_OFF;
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= pat ^ {7{SEG_ACTIVE_LOW}};
      dp_q  <= (digit_idx_q == 2'd3) ^ SEG_ACTIVE_LOW;
      an_q  <= (4'b0001 << digit_idx_q) ^ {4{AN_ACTIVE_LOW}};
    end
  end

  assign seg_o = seg_q;
  assign dp_o  = dp_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_seg7_indicator_ctrl.sv
// Self-checking bench for seg7_indicator_ctrl: directed sequences, a vector
// table and randomized traffic against an arithmetic reference model.
module tb_seg7_indicator_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'd0;
  logic [1:0]  mode = 2'd0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic [11:0] bcd_o;
  logic        busy_o;

  always #5 clk = ~clk;

  seg7_indicator_ctrl #(.SCAN_DIV(SD)) u_dut (
    .clc_i (clk),
    .rst_i (rst),
    .data_i(data),
    .mode_i(mode),
    .seg_o (seg_o),
    .dp_o  (dp_o),
    .an_o  (an_o),
    .bcd_o (bcd_o),
    .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_lat   = 0;
  int         m_val   = 0;
  int         m_left  = 0;
  int         m_ticks = 0;
  logic [6:0] m_seg   = 7'h7F;
  logic       m_dp    = 1'b1;
  logic [3:0] m_an    = 4'hF;

  typedef struct packed {
    logic [7:0]  data;
    logic [11:0] bcd;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] disp_pat(input int idx, input int v, input int md);
    case (idx)
      0:       return pat_of(v % 10);
      1:       return (v >= 10) ? pat_of((v / 10) % 10) : 7'h00;
      2:       return (v >= 100) ? pat_of(v / 100) : 7'h00;
      default: return (md == 0) ? 7'h40 : pat_of(md);
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    int idx;
    if (rst) begin
      m_lat = 0; m_val = 0; m_left = 0; m_ticks = 0;
      m_seg = 7'h7F; m_dp = 1'b1; m_an = 4'hF;
    end else begin
      idx     = (m_ticks / SD) % 4;
      m_seg   = ~disp_pat(idx, m_val, int'(mode));
      m_dp    = (idx != 3);
      m_an    = ~(4'b0001 << idx);
      m_ticks = m_ticks + 1;
      if (m_left == 0) begin
        if (int'(data) != m_lat) begin
          m_lat  = int'(data);
          m_left = 9;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_val = m_lat;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_bcd",  32'(bcd_o),  32'(to_bcd(m_val)));
    chk("model_busy", 32'(busy_o), 32'(m_left != 0));
    chk("model_seg",  32'(seg_o),  32'(m_seg));
    chk("model_dp",   32'(dp_o),   32'(m_dp));
    chk("model_an",   32'(an_o),   32'(m_an));
  endtask

  task automatic wait_an(input logic [3:0] p);
    int n = 0;
    while (an_o !== p && n < 64) begin
      step();
      n++;
    end
    chk("wait_an", 32'(an_o), 32'(p));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] scan_seq [4];
    vecs[0] = '{8'd7,   12'h007};
    vecs[1] = '{8'd100, 12'h100};
    vecs[2] = '{8'd42,  12'h042};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd10,  12'h010};
    vecs[5] = '{8'd1,   12'h001};
    vecs[6] = '{8'd0,   12'h000};
    vecs[7] = '{8'd255, 12'h255};
    vecs[8] = '{8'd128, 12'h128};
    vecs[9] = '{8'd201, 12'h201};
    scan_seq[0] = 4'b1110; scan_seq[1] = 4'b1101;
    scan_seq[2] = 4'b1011; scan_seq[3] = 4'b0111;

    // reset state
    rst = 1'b1; data = 8'd0; mode = 2'd0;
    repeat (3) step();
    chk("rst_bcd",  32'(bcd_o),  32'h000);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_an",   32'(an_o),   32'hF);
    chk("rst_seg",  32'(seg_o),  32'h7F);
    chk("rst_dp",   32'(dp_o),   32'd1);
    rst = 1'b0;
    step();
    chk("rel_busy0", 32'(busy_o), 32'd0);
    step();
    chk("rel_busy1", 32'(busy_o), 32'd0);

    // full-scale conversion latency
    data = 8'd255;
    step();
    chk("c255_busy_first", 32'(busy_o), 32'd1);
    repeat (8) step();
    chk("c255_busy_9th", 32'(busy_o), 32'd1);
    chk("c255_bcd_9th",  32'(bcd_o),  32'h000);
    step();
    chk("c255_bcd",  32'(bcd_o),  32'h255);
    chk("c255_busy", 32'(busy_o), 32'd0);

    // digit content with leading-zero blanking
    data = 8'd7;
    repeat (11) step();
    chk("c7_bcd", 32'(bcd_o), 32'h007);
    wait_an(4'b1110); chk("c7_units",    32'(seg_o), 32'h78);
    wait_an(4'b1101); chk("c7_tens",     32'(seg_o), 32'h7F);
    wait_an(4'b1011); chk("c7_hundreds", 32'(seg_o), 32'h7F);
    data = 8'd100;
    repeat (11) step();
    wait_an(4'b1101); chk("c100_tens",     32'(seg_o), 32'h40);
    wait_an(4'b1011); chk("c100_hundreds", 32'(seg_o), 32'h79);
    wait_an(4'b1110); chk("c100_units",    32'(seg_o), 32'h40);

    // data change while busy is deferred to the next IDLE
    data = 8'd0;
    repeat (11) step();
    data = 8'd100;
    step();
    chk("defer_busy", 32'(busy_o), 32'd1);
    repeat (2) step();
    data = 8'd42;
    repeat (7) step();
    chk("defer_bcd100",  32'(bcd_o),  32'h100);
    chk("defer_idle",    32'(busy_o), 32'd0);
    step();
    chk("defer_rebusy",  32'(busy_o), 32'd1);
    repeat (9) step();
    chk("defer_bcd042",  32'(bcd_o),  32'h042);
    chk("defer_done",    32'(busy_o), 32'd0);

    // scan timing and mode digit
    mode = 2'd2;
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < SD; k++) begin
        chk("scan_an", 32'(an_o), 32'(scan_seq[p]));
        if (p == 3) begin
          chk("mode2_seg", 32'(seg_o), 32'h24);
          chk("mode2_dp",  32'(dp_o),  32'd0);
        end else begin
          chk("digit_dp",  32'(dp_o),  32'd1);
        end
        step();
      end
    end
    chk("scan_wrap", 32'(an_o), 32'b1110);
    mode = 2'd0;
    wait_an(4'b0111);
    chk("mode0_dash", 32'(seg_o), 32'h3F);

    // reset in the middle of a conversion
    data = 8'd200;
    step();
    repeat (4) step();
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_bcd",  32'(bcd_o),  32'h000);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_an",   32'(an_o),   32'hF);
    rst = 1'b0;
    step();
    chk("restart_busy", 32'(busy_o), 32'd1);
    repeat (9) step();
    chk("restart_bcd",  32'(bcd_o),  32'h200);

    // vector table
    for (int i = 0; i < 10; i++) begin
      data = vecs[i].data;
      step();
      chk("vec_busy", 32'(busy_o), 32'd1);
      repeat (9) step();
      chk("vec_bcd",  32'(bcd_o),  32'(vecs[i].bcd));
      chk("vec_idle", 32'(busy_o), 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)   data = 8'($urandom);
      if ($urandom_range(15) == 0)  mode = 2'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
